// File: rtl/vector_loader_pkg.sv
// rtl/vector_loader_pkg.sv - shared FSM state type and sizing helpers for the vector loader
package vector_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    RUN    = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam int DEFAULT_DRAIN_CYCLES = 8;

  // Run counter must hold MEM_SIZE + drain margin; five extra bits over the address is ample.
  function automatic int run_cnt_width(input int addr_width);
    return addr_width + 5;
  endfunction

endpackage

// File: rtl/vector_loader_if.sv
// rtl/vector_loader_if.sv - valid/ready word stream feeding the vector loader
interface vector_loader_if #(
  parameter int DATA_WIDTH = 32
) ();

  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_last;

  modport master (
    output s_valid,
    output s_data,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  s_last,
    output s_ready
  );

endinterface

// File: rtl/vector_loader.sv
// rtl/vector_loader.sv - loads vectors A and B from a stream into operand memories, then runs
// Optional checksum output enabled by VECTOR_LOADER_CKSUM_EN.
module vector_loader
  import vector_loader_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int MEM_SIZE     = 32,
  parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  go_i,
  input  logic [ADDR_WIDTH:0]   cfg_len_i,
  vector_loader_if.slave        s,
  output logic                  mem1_write_en_o,
  output logic [ADDR_WIDTH-1:0] mem1_write_address_o,
  output logic [DATA_WIDTH-1:0] mem1_data_in_o,
  output logic                  mem2_write_en_o,
  output logic [ADDR_WIDTH-1:0] mem2_write_address_o,
  output logic [DATA_WIDTH-1:0] mem2_data_in_o,
  output logic                  start_processing_o,
  output logic                  busy_o,
  output logic                  done_o,
`ifdef VECTOR_LOADER_CKSUM_EN
  output logic [DATA_WIDTH-1:0] cksum_o,
`endif
  output logic                  len_err_o
);

  localparam int LW = ADDR_WIDTH + 1;
  localparam int RW = run_cnt_width(ADDR_WIDTH);

  state_e                state_q;
  logic [LW-1:0]         len_q;
  logic [LW-1:0]         cnt_q;
  logic [RW-1:0]         run_cnt_q;
  logic                  ready_q;
  logic                  busy_q;
  logic                  start_q;
  logic                  done_q;
  logic                  len_err_q;

  // One write path shared by both memories; wr_sel_q picks the target (0 = mem1, 1 = mem2).
  logic                  wr_en_q;
  logic                  wr_sel_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
`ifdef VECTOR_LOADER_CKSUM_EN
  logic [DATA_WIDTH-1:0] cksum_q;
`endif

  logic          beat;
  logic          final_beat;
  logic [LW-1:0] len_d;
  logic [LW-1:0] cnt_d;
  logic [RW-1:0] run_last;

  assign beat       = s.s_valid && ready_q;
  assign final_beat = (cnt_q == len_q - LW'(1));
  assign len_d      = (cfg_len_i > LW'(MEM_SIZE)) ? LW'(MEM_SIZE) : cfg_len_i;
  assign cnt_d      = cnt_q + LW'(1);
  assign run_last   = RW'(len_q) + RW'(DRAIN_CYCLES) - RW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      run_cnt_q <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      len_err_q <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_sel_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
`ifdef VECTOR_LOADER_CKSUM_EN
      cksum_q   <= '0;
`endif
    end else begin
      wr_en_q <= beat;
      if (beat) begin
        wr_sel_q  <= (state_q == LOAD_B);
        wr_addr_q <= cnt_q[ADDR_WIDTH-1:0];
        wr_data_q <= s.s_data;
`ifdef VECTOR_LOADER_CKSUM_EN
        cksum_q   <= cksum_q ^ s.s_data;
`endif
      end

      case (state_q)
        IDLE: begin
          if (go_i) begin
            len_q <= len_d;
            cnt_q <= '0;
`ifdef VECTOR_LOADER_CKSUM_EN
            cksum_q <= '0;
`endif
            if (len_d == '0) begin
              len_err_q <= 1'b1;
            end else begin
              len_err_q <= 1'b0;
              state_q   <= LOAD_A;
              ready_q   <= 1'b1;
              busy_q    <= 1'b1;
            end
          end
        end

        LOAD_A, LOAD_B: begin
          if (beat) begin
            if (final_beat || s.s_last) begin
              cnt_q <= '0;
              // s_last must coincide exactly with the len-th word.
              if (final_beat != s.s_last) len_err_q <= 1'b1;
              if (state_q == LOAD_A) begin
                state_q <= LOAD_B;
              end else begin
                state_q   <= RUN;
                ready_q   <= 1'b0;
                start_q   <= 1'b1;
                run_cnt_q <= '0;
              end
            end else begin
              cnt_q <= cnt_d;
            end
          end
        end

        RUN: begin
          if (run_cnt_q == run_last) begin
            state_q <= DONE;
            start_q <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            run_cnt_q <= run_cnt_q + RW'(1);
          end
        end

        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          start_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign s.s_ready            = ready_q;
  assign mem1_write_en_o      = wr_en_q && !wr_sel_q;
  assign mem1_write_address_o = wr_addr_q;
  assign mem1_data_in_o       = wr_data_q;
  assign mem2_write_en_o      = wr_en_q && wr_sel_q;
  assign mem2_write_address_o = wr_addr_q;
  assign mem2_data_in_o       = wr_data_q;
  assign start_processing_o   = start_q;
  assign busy_o               = busy_q;
  assign done_o               = done_q;
  assign len_err_o            = len_err_q;
`ifdef VECTOR_LOADER_CKSUM_EN
  assign cksum_o              = cksum_q;
`endif

endmodule
